// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory access stage: FSM states, access size codes
// and the alignment rule used at request accept.
package mem_access_unit_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      WRITE,
      DONE,
      ERR
   } state_t;

   localparam logic [1:0] SIZE_WORD = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_BYTE = 2'b10;

   // Size code 2'b11 falls into the word rule, matching its word treatment.
   function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLsb);
      case (size)
         SIZE_HALF: isMisaligned = addrLsb[0];
         SIZE_BYTE: isMisaligned = 1'b0;
         default:   isMisaligned = (addrLsb != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request, register and memory-bus signals of the memory access stage.
// slave is the access unit; master is the control unit / datapath / memory side.
interface mem_access_unit_if;

   logic        req_valid;
   logic        req_ready;
   logic        i_or_d;
   logic        mem_write;
   logic        ir_write;
   logic [1:0]  size;
   logic [31:0] pc;
   logic [31:0] alu_out;
   logic [31:0] store_data;
   logic [31:0] mem_addr;
   logic        mem_wr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [31:0] ir;
   logic [31:0] mdr;
   logic        done;
   logic        misaligned;

   modport slave (
      input  req_valid, i_or_d, mem_write, ir_write, size, pc, alu_out, store_data, mem_rdata,
      output req_ready, mem_addr, mem_wr, mem_wdata, ir, mdr, done, misaligned
   );

   modport master (
      output req_valid, i_or_d, mem_write, ir_write, size, pc, alu_out, store_data, mem_rdata,
      input  req_ready, mem_addr, mem_wr, mem_wdata, ir, mdr, done, misaligned
   );

endinterface

// File: rtl/mem_access_unit_store_merge.sv
// Little-endian lane merge for sub-word stores: the addressed byte or halfword
// of the read word is replaced by the low bits of the store operand.
module mem_access_unit_store_merge
   import mem_access_unit_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [31:0] wdata_i,
   input  logic [1:0]  addrLsb_i,
   input  logic [1:0]  size_i,
   output logic [31:0] merged_o
);

   always_comb begin
      merged_o = rdata_i;
      case (size_i)
         SIZE_BYTE: begin
            case (addrLsb_i)
               2'd0:    merged_o[7:0]   = wdata_i[7:0];
               2'd1:    merged_o[15:8]  = wdata_i[7:0];
               2'd2:    merged_o[23:16] = wdata_i[7:0];
               default: merged_o[31:24] = wdata_i[7:0];
            endcase
         end
         SIZE_HALF: begin
            if (addrLsb_i[1]) merged_o[31:16] = wdata_i[15:0];
            else              merged_o[15:0]  = wdata_i[15:0];
         end
         default: merged_o = wdata_i;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-side stage of the multicycle datapath: selects PC or ALUOut, sequences
// fixed-latency reads and writes, loads IR/MDR and performs sub-word read-modify-write.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int MEM_LATENCY = 1
)
(
   input  logic             clock,
   input  logic             reset,
   mem_access_unit_if.slave bus
);

   if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_badLatency
      $error("mem_access_unit: MEM_LATENCY must lie in 1..15");
   end

   localparam logic [3:0] LAT_RELOAD = 4'(MEM_LATENCY - 1);

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [1:0]  size_q;
   logic [1:0]  addrLsb_q;
   logic        isStore_q;
   logic        toIr_q;
   logic [31:0] storeData_q;
   logic [31:0] memAddr_q;
   logic [31:0] memWdata_q;
   logic        memWr_q;
   logic [31:0] ir_q;
   logic [31:0] mdr_q;
   logic        done_q;
   logic        misaligned_q;

   logic [31:0] reqAddr;
   logic [1:0]  reqSize;
   logic [31:0] mergedWord;

   assign reqAddr = bus.i_or_d ? bus.alu_out : bus.pc;
   assign reqSize = (bus.size == 2'b11) ? SIZE_WORD : bus.size;

   mem_access_unit_store_merge u_storeMerge (
      .rdata_i   (bus.mem_rdata),
      .wdata_i   (storeData_q),
      .addrLsb_i (addrLsb_q),
      .size_i    (size_q),
      .merged_o  (mergedWord)
   );

   // Strobes default low so done, misaligned and mem_wr last exactly one cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         size_q       <= SIZE_WORD;
         addrLsb_q    <= '0;
         isStore_q    <= 1'b0;
         toIr_q       <= 1'b0;
         storeData_q  <= '0;
         memAddr_q    <= '0;
         memWdata_q   <= '0;
         memWr_q      <= 1'b0;
         ir_q         <= '0;
         mdr_q        <= '0;
         done_q       <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         memWr_q      <= 1'b0;
         done_q       <= 1'b0;
         misaligned_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  size_q      <= reqSize;
                  addrLsb_q   <= reqAddr[1:0];
                  isStore_q   <= bus.mem_write;
                  toIr_q      <= bus.ir_write;
                  storeData_q <= bus.store_data;
                  // A misaligned access leaves the memory bus untouched.
                  if (isMisaligned(reqSize, reqAddr[1:0])) begin
                     state_q      <= ERR;
                     done_q       <= 1'b1;
                     misaligned_q <= 1'b1;
                  end else if (bus.mem_write && reqSize == SIZE_WORD) begin
                     state_q    <= WRITE;
                     memAddr_q  <= {reqAddr[31:2], 2'b00};
                     memWdata_q <= bus.store_data;
                     memWr_q    <= 1'b1;
                  end else begin
                     state_q   <= RD_WAIT;
                     memAddr_q <= {reqAddr[31:2], 2'b00};
                     cnt_q     <= LAT_RELOAD;
                  end
               end
            end
            RD_WAIT: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else if (isStore_q) begin
                  state_q    <= WRITE;
                  memWdata_q <= mergedWord;
                  memWr_q    <= 1'b1;
               end else begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  if (toIr_q) ir_q  <= bus.mem_rdata;
                  else        mdr_q <= bus.mem_rdata;
               end
            end
            WRITE: begin
               state_q <= DONE;
               done_q  <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.mem_addr   = memAddr_q;
   assign bus.mem_wr     = memWr_q;
   assign bus.mem_wdata  = memWdata_q;
   assign bus.ir         = ir_q;
   assign bus.mdr        = mdr_q;
   assign bus.done       = done_q;
   assign bus.misaligned = misaligned_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a latency-1 and a latency-3 instance, each with its
// own word memory, checked against a size/alignment reference model.
module tb_mem_access_unit;

   logic clock = 1'b0;
   logic reset = 1'b1;

   always #5 clock = ~clock;

   mem_access_unit_if bus1 ();
   mem_access_unit_if bus3 ();

   mem_access_unit #(.MEM_LATENCY(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
   mem_access_unit #(.MEM_LATENCY(3)) dut3 (.clock(clock), .reset(reset), .bus(bus3));

   // Shared request fields; only the selected instance sees req_valid.
   logic        reqValid1 = 1'b0;
   logic        reqValid3 = 1'b0;
   logic        drvIorD = 1'b0;
   logic        drvStore = 1'b0;
   logic        drvToIr = 1'b0;
   logic [1:0]  drvSize = 2'b00;
   logic [31:0] drvPc = '0;
   logic [31:0] drvAlu = '0;
   logic [31:0] drvData = '0;

   assign bus1.req_valid  = reqValid1;
   assign bus3.req_valid  = reqValid3;
   assign bus1.i_or_d     = drvIorD;
   assign bus3.i_or_d     = drvIorD;
   assign bus1.mem_write  = drvStore;
   assign bus3.mem_write  = drvStore;
   assign bus1.ir_write   = drvToIr;
   assign bus3.ir_write   = drvToIr;
   assign bus1.size       = drvSize;
   assign bus3.size       = drvSize;
   assign bus1.pc         = drvPc;
   assign bus3.pc         = drvPc;
   assign bus1.alu_out    = drvAlu;
   assign bus3.alu_out    = drvAlu;
   assign bus1.store_data = drvData;
   assign bus3.store_data = drvData;

   // Word memories: latency 1 reads combinationally, latency 3 through a two-stage address pipe.
   logic [31:0] mem1 [64];
   logic [31:0] mem3 [64];
   logic [31:0] addrPipe1 = '0;
   logic [31:0] addrPipe2 = '0;

   assign bus1.mem_rdata = mem1[bus1.mem_addr[7:2]];
   assign bus3.mem_rdata = mem3[addrPipe2[7:2]];

   always @(posedge clock) begin
      addrPipe1 <= bus3.mem_addr;
      addrPipe2 <= addrPipe1;
      if (bus1.mem_wr) mem1[bus1.mem_addr[7:2]] = bus1.mem_wdata;
      if (bus3.mem_wr) mem3[bus3.mem_addr[7:2]] = bus3.mem_wdata;
   end

   logic        sel = 1'b0;
   logic        obsReady, obsDone, obsMis, obsWr;
   logic [31:0] obsAddr, obsWdata, obsIr, obsMdr;

   assign obsReady = sel ? bus3.req_ready  : bus1.req_ready;
   assign obsDone  = sel ? bus3.done       : bus1.done;
   assign obsMis   = sel ? bus3.misaligned : bus1.misaligned;
   assign obsWr    = sel ? bus3.mem_wr     : bus1.mem_wr;
   assign obsAddr  = sel ? bus3.mem_addr   : bus1.mem_addr;
   assign obsWdata = sel ? bus3.mem_wdata  : bus1.mem_wdata;
   assign obsIr    = sel ? bus3.ir         : bus1.ir;
   assign obsMdr   = sel ? bus3.mdr        : bus1.mdr;

   int checks = 0;
   int errors = 0;
   logic [31:0] modelIr  [2];
   logic [31:0] modelMdr [2];

   // Issues one request and records what the bus did, counting cycles from the accept edge.
   task automatic applyStimulus(input bit s, input bit iOrD, input bit isStore, input bit toIr,
                                input logic [1:0] sz, input logic [31:0] pcV, input logic [31:0] aluV,
                                input logic [31:0] dataV, input int pulseAt,
                                output int doneCycle, output bit misSeen, output int wrCount,
                                output logic [31:0] wrData, output logic [31:0] wrAddr,
                                output logic [31:0] rdAddr);
      int guard;
      sel = s;
      guard = 0;
      while (!obsReady && guard < 50) begin
         @(posedge clock); #1;
         guard++;
      end
      drvIorD = iOrD; drvStore = isStore; drvToIr = toIr; drvSize = sz;
      drvPc = pcV; drvAlu = aluV; drvData = dataV;
      if (s) reqValid3 = 1'b1; else reqValid1 = 1'b1;
      @(posedge clock); #1;
      reqValid1 = 1'b0; reqValid3 = 1'b0;
      doneCycle = -1; misSeen = 1'b0; wrCount = 0; wrData = '0; wrAddr = '0;
      rdAddr = obsAddr;
      for (int c = 1; c <= 40; c++) begin
         if (obsWr) begin
            wrCount++;
            wrData = obsWdata;
            wrAddr = obsAddr;
         end
         if (obsDone) begin
            doneCycle = c;
            misSeen = obsMis;
            break;
         end
         if (c == pulseAt) begin
            if (s) reqValid3 = 1'b1; else reqValid1 = 1'b1;
         end else begin
            reqValid1 = 1'b0; reqValid3 = 1'b0;
         end
         @(posedge clock); #1;
      end
      reqValid1 = 1'b0; reqValid3 = 1'b0;
   endtask

   task automatic test_reset();
      logic [131:0] expVec;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      expVec = {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
      checks++;
      if ({bus1.req_ready, bus1.done, bus1.misaligned, bus1.mem_wr, bus1.mem_addr, bus1.mem_wdata, bus1.ir, bus1.mdr} !== expVec) begin
         errors++;
         $display("[TB] FAIL reset_lat1 got %h want %h", {bus1.req_ready, bus1.done, bus1.misaligned, bus1.mem_wr, bus1.mem_addr, bus1.mem_wdata, bus1.ir, bus1.mdr}, expVec);
      end
      checks++;
      if ({bus3.req_ready, bus3.done, bus3.misaligned, bus3.mem_wr, bus3.mem_addr, bus3.mem_wdata, bus3.ir, bus3.mdr} !== expVec) begin
         errors++;
         $display("[TB] FAIL reset_lat3 got %h want %h", {bus3.req_ready, bus3.done, bus3.misaligned, bus3.mem_wr, bus3.mem_addr, bus3.mem_wdata, bus3.ir, bus3.mdr}, expVec);
      end
      reset = 1'b0;
      @(posedge clock); #1;
      modelIr[0] = '0; modelIr[1] = '0; modelMdr[0] = '0; modelMdr[1] = '0;
   endtask

   task automatic test_fetch();
      int dc, wc;
      bit mis;
      logic [31:0] wd, wa, ra;
      mem1[4] = 32'h8C220004;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h10, $urandom, $urandom, 0, dc, mis, wc, wd, wa, ra);
      checks++;
      if (dc !== 2) begin errors++; $display("[TB] FAIL fetch_done_cycle got %0d want 2", dc); end
      checks++;
      if (ra !== 32'h10) begin errors++; $display("[TB] FAIL fetch_mem_addr got %h want 00000010", ra); end
      checks++;
      if (obsIr !== 32'h8C220004) begin errors++; $display("[TB] FAIL fetch_ir got %h want 8c220004", obsIr); end
      checks++;
      if (mis !== 1'b0 || wc !== 0) begin errors++; $display("[TB] FAIL fetch_side_effects mis=%0b writes=%0d want 0/0", mis, wc); end
      modelIr[0] = 32'h8C220004;
      mem1[12] = 32'h55AA1234;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b11, $urandom, 32'h30, $urandom, 0, dc, mis, wc, wd, wa, ra);
      checks++;
      if (obsMdr !== 32'h55AA1234 || obsIr !== 32'h8C220004) begin
         errors++;
         $display("[TB] FAIL load_mdr got mdr=%h ir=%h want 55aa1234/8c220004", obsMdr, obsIr);
      end
      modelMdr[0] = 32'h55AA1234;
   endtask

   task automatic test_store_byte();
      int dc, wc;
      bit mis;
      logic [31:0] wd, wa, ra;
      mem1[8] = 32'h11223344;
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 2'b10, $urandom, 32'h23, 32'h000000AB, 0, dc, mis, wc, wd, wa, ra);
      checks++;
      if (dc !== 3) begin errors++; $display("[TB] FAIL sb_done_cycle got %0d want 3", dc); end
      checks++;
      if (wc !== 1 || wd !== 32'hAB223344 || wa !== 32'h20) begin
         errors++;
         $display("[TB] FAIL sb_write got n=%0d data=%h addr=%h want 1/ab223344/00000020", wc, wd, wa);
      end
      checks++;
      if (obsIr !== modelIr[0] || obsMdr !== modelMdr[0]) begin
         errors++;
         $display("[TB] FAIL sb_regs_kept got ir=%h mdr=%h want %h/%h", obsIr, obsMdr, modelIr[0], modelMdr[0]);
      end
   endtask

   task automatic test_store_half();
      int dc, wc;
      bit mis;
      logic [31:0] wd, wa, ra;
      mem1[8] = 32'h11223344;
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, $urandom, 32'h22, 32'h0000BEEF, 0, dc, mis, wc, wd, wa, ra);
      checks++;
      if (wc !== 1 || wd !== 32'hBEEF3344 || dc !== 3) begin
         errors++;
         $display("[TB] FAIL sh_upper got n=%0d data=%h cycle=%0d want 1/beef3344/3", wc, wd, dc);
      end
      mem1[8] = 32'h11223344;
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'b01, $urandom, 32'h20, 32'h1234BEEF, 0, dc, mis, wc, wd, wa, ra);
      checks++;
      if (wc !== 1 || wd !== 32'h1122BEEF) begin
         errors++;
         $display("[TB] FAIL sh_lower got n=%0d data=%h want 1/1122beef", wc, wd);
      end
      checks++;
      if (mem1[8] !== 32'h1122BEEF) begin errors++; $display("[TB] FAIL sh_mem_image got %h want 1122beef", mem1[8]); end
   endtask

   task automatic test_misaligned();
      int dc, wc;
      bit mis;
      logic [31:0] wd, wa, ra;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, $urandom, 32'h21, $urandom, 0, dc, mis, wc, wd, wa, ra);
      checks++;
      if (dc !== 1 || mis !== 1'b1) begin errors++; $display("[TB] FAIL lw_misaligned got cycle=%0d mis=%0b want 1/1", dc, mis); end
      checks++;
      if (wc !== 0 || obsMdr !== modelMdr[0]) begin
         errors++;
         $display("[TB] FAIL lw_misaligned_effects got writes=%0d mdr=%h want 0/%h", wc, obsMdr, modelMdr[0]);
      end
   endtask

   task automatic test_latency3();
      int dc, wc, extraDone;
      bit mis;
      logic [31:0] wd, wa, ra;
      mem3[16] = 32'hCAFEF00D;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, $urandom, 32'h40, $urandom, 2, dc, mis, wc, wd, wa, ra);
      checks++;
      if (dc !== 4) begin errors++; $display("[TB] FAIL lat3_done_cycle got %0d want 4", dc); end
      checks++;
      if (obsMdr !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL lat3_mdr got %h want cafef00d", obsMdr); end
      modelMdr[1] = 32'hCAFEF00D;
      @(posedge clock); #1;
      checks++;
      if (obsReady !== 1'b1) begin errors++; $display("[TB] FAIL lat3_ready_after got %0b want 1", obsReady); end
      extraDone = 0;
      for (int i = 0; i < 6; i++) begin
         if (obsDone) extraDone++;
         @(posedge clock); #1;
      end
      checks++;
      if (extraDone !== 0) begin errors++; $display("[TB] FAIL lat3_busy_req_ignored got %0d extra done want 0", extraDone); end
   endtask

   task automatic test_reset_midop();
      int wrSeen;
      sel = 1'b1;
      drvIorD = 1'b1; drvStore = 1'b1; drvToIr = 1'b0; drvSize = 2'b10;
      drvAlu = 32'h45; drvData = 32'h000000EE;
      reqValid3 = 1'b1;
      @(posedge clock); #1;
      reqValid3 = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      checks++;
      if ({obsReady, obsWr, obsDone, obsIr, obsMdr} !== {1'b1, 1'b0, 1'b0, 32'h0, 32'h0}) begin
         errors++;
         $display("[TB] FAIL reset_midop got ready=%0b wr=%0b done=%0b ir=%h mdr=%h want 1/0/0/0/0", obsReady, obsWr, obsDone, obsIr, obsMdr);
      end
      reset = 1'b0;
      wrSeen = 0;
      for (int i = 0; i < 6; i++) begin
         if (obsWr) wrSeen++;
         @(posedge clock); #1;
      end
      checks++;
      if (wrSeen !== 0) begin errors++; $display("[TB] FAIL reset_midop_write_dropped got %0d writes want 0", wrSeen); end
      modelIr[0] = '0; modelIr[1] = '0; modelMdr[0] = '0; modelMdr[1] = '0;
   endtask

   // Reference model: alignment, latency and lane replacement from plain arithmetic.
   task automatic test_random();
      int dc, wc, expDone, lat;
      bit mis, s, iOrD, st, toIr, expMis;
      logic [1:0]  sz;
      logic [31:0] pcV, aluV, dataV, addr, w, expWd, mask, wd, wa, ra;
      int sh;
      for (int n = 0; n < 60; n++) begin
         s = 1'($urandom_range(0, 1)); iOrD = 1'($urandom_range(0, 1));
         st = 1'($urandom_range(0, 1)); toIr = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         pcV = $urandom; aluV = $urandom; dataV = $urandom; w = $urandom;
         addr = iOrD ? aluV : pcV;
         if (s) mem3[addr[7:2]] = w; else mem1[addr[7:2]] = w;
         lat = s ? 3 : 1;
         expMis = (sz == 2'b01) ? addr[0] : (sz == 2'b10) ? 1'b0 : (addr[1:0] != 2'b00);
         if (expMis) expDone = 1;
         else if (st && (sz == 2'b00 || sz == 2'b11)) expDone = 2;
         else if (st) expDone = lat + 2;
         else expDone = lat + 1;
         if (sz == 2'b10) begin
            sh = 8 * int'(addr[1:0]); mask = 32'hFF << sh;
            expWd = (w & ~mask) | ((dataV & 32'hFF) << sh);
         end else if (sz == 2'b01) begin
            sh = 16 * int'(addr[1]); mask = 32'hFFFF << sh;
            expWd = (w & ~mask) | ((dataV & 32'hFFFF) << sh);
         end else begin
            expWd = dataV;
         end
         if (!expMis && !st) begin
            if (toIr) modelIr[s] = w; else modelMdr[s] = w;
         end
         applyStimulus(s, iOrD, st, toIr, sz, pcV, aluV, dataV, 0, dc, mis, wc, wd, wa, ra);
         checks++;
         if (dc !== expDone || mis !== expMis) begin
            errors++;
            $display("[TB] FAIL rand_timing[%0d] got cycle=%0d mis=%0b want %0d/%0b", n, dc, mis, expDone, expMis);
         end
         checks++;
         if (wc !== ((st && !expMis) ? 1 : 0)) begin
            errors++;
            $display("[TB] FAIL rand_write_count[%0d] got %0d want %0d", n, wc, (st && !expMis) ? 1 : 0);
         end
         if (st && !expMis) begin
            checks++;
            if (wd !== expWd || wa !== {addr[31:2], 2'b00}) begin
               errors++;
               $display("[TB] FAIL rand_wdata[%0d] got %h@%h want %h@%h", n, wd, wa, expWd, {addr[31:2], 2'b00});
            end
         end
         if (!st && !expMis) begin
            checks++;
            if (ra !== {addr[31:2], 2'b00}) begin
               errors++;
               $display("[TB] FAIL rand_rd_addr[%0d] got %h want %h", n, ra, {addr[31:2], 2'b00});
            end
         end
         checks++;
         if (obsIr !== modelIr[s] || obsMdr !== modelMdr[s]) begin
            errors++;
            $display("[TB] FAIL rand_regs[%0d] got ir=%h mdr=%h want %h/%h", n, obsIr, obsMdr, modelIr[s], modelMdr[s]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem1[i] = '0;
         mem3[i] = '0;
      end
      test_reset();
      test_fetch();
      test_store_byte();
      test_store_half();
      test_misaligned();
      test_latency3();
      test_reset_midop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
